// File: rtl/axi_w_stream_gen_pkg.sv
// axi_w_stream_gen_pkg: shared types and helpers for the AXI W-channel stream generator.
package axi_w_stream_gen_pkg;

  typedef enum logic [1:0] {
    PAT_INCR  = 2'd0,
    PAT_FIXED = 2'd1,
    PAT_LFSR  = 2'd2
  } pattern_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_CREDIT = 2'd1,
    ST_DATA        = 2'd2
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // The reserved encoding 3 behaves as INCR.
  function automatic pattern_mode_e decode_mode(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAT_FIXED;
      2'd2:    return PAT_LFSR;
      default: return PAT_INCR;
    endcase
  endfunction

  // One Galois step, shifting right and folding the taps in when bit 0 drops out.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/axi_w_pattern_gen.sv
// axi_w_pattern_gen: 32-bit data pattern register (INCR / FIXED / LFSR).
module axi_w_pattern_gen
  import axi_w_stream_gen_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          advance_i,
  input  pattern_mode_e mode_i,
  input  logic [31:0]   seed_i,
  output logic [31:0]   word_o
);

  logic [31:0] pat_q;

  // Load from the seed on start, otherwise step once per accepted beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pat_q <= '0;
    end else if (load_i) begin
      // An all-zero LFSR would lock up, so a zero seed becomes 1.
      pat_q <= (mode_i == PAT_LFSR && seed_i == '0) ? 32'd1 : seed_i;
    end else if (advance_i) begin
      case (mode_i)
        PAT_INCR: pat_q <= pat_q + 32'd1;
        PAT_LFSR: pat_q <= lfsr_next(pat_q);
        default:  pat_q <= pat_q;
      endcase
    end
  end

  assign word_o = pat_q;

endmodule

// File: rtl/axi_w_stream_gen.sv
// axi_w_stream_gen: AXI4 W-channel traffic generator, bursts released by AW credits.
// Optional feature: define AXI_W_STREAM_GEN_STALL_CNT_EN to add stall_cycles_o.
//
// state          | meaning
// ST_IDLE        | waiting for start_i; config latched on an accepted start
// ST_WAIT_CREDIT | a burst is pending but no AW credit is held yet
// ST_DATA        | driving the W beats of the current burst
module axi_w_stream_gen
  import axi_w_stream_gen_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int BURST_CNT_WIDTH = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int CREDIT_WIDTH    = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [7:0]                 cfg_len_i,
  input  logic [BURST_CNT_WIDTH-1:0] cfg_bursts_i,
  input  logic [1:0]                 cfg_mode_i,
  input  logic [31:0]                cfg_seed_i,
  input  logic                       aw_hs_i,
  output logic                       w_valid_o,
  output logic [DATA_WIDTH-1:0]      w_data_o,
  output logic [DATA_WIDTH/8-1:0]    w_strb_o,
  output logic                       w_last_o,
  input  logic                       w_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       credit_err_o
`ifdef AXI_W_STREAM_GEN_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cycles_o
`endif
);

  localparam logic [BURST_CNT_WIDTH-1:0] BURST_ONE = BURST_CNT_WIDTH'(1);
  localparam logic [CREDIT_WIDTH-1:0]    CRED_ONE  = CREDIT_WIDTH'(1);
  localparam logic [CREDIT_WIDTH-1:0]    CRED_MAX  = CREDIT_WIDTH'(MAX_OUTSTANDING);

  state_e                     state_q, state_d;
  logic [7:0]                 len_q, beat_q;
  logic [BURST_CNT_WIDTH-1:0] bursts_q, burst_q;
  pattern_mode_e              mode_q, pat_mode;
  logic [CREDIT_WIDTH-1:0]    credit_q, credit_d;
  logic                       cred_ovf;
  logic                       err_q, done_q;
  logic                       accept, hs, last_hs, final_burst, run_end;
  logic [31:0]                pat_word;

  assign hs          = w_valid_o && w_ready_i;
  assign last_hs     = hs && w_last_o;
  assign final_burst = (burst_q == bursts_q - BURST_ONE);
  assign run_end     = last_hs && final_burst;

  // Credit arithmetic: AW adds, the last beat of a burst consumes; a full counter drops extras.
  always_comb begin
    credit_d = credit_q;
    cred_ovf = 1'b0;
    if (aw_hs_i && !last_hs) begin
      if (credit_q == CRED_MAX) cred_ovf = 1'b1;
      else                      credit_d = credit_q + CRED_ONE;
    end else if (!aw_hs_i && last_hs) begin
      credit_d = credit_q - CRED_ONE;
    end
  end

  // Next-state decode; start is honoured only in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept = 1'b1;
          if (cfg_bursts_i != '0) state_d = ST_WAIT_CREDIT;
        end
      end
      ST_WAIT_CREDIT: begin
        if (credit_q != '0) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (last_hs) begin
          if (final_burst)          state_d = ST_IDLE;
          else if (credit_d == '0)  state_d = ST_WAIT_CREDIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Run configuration, captured on an accepted start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q    <= '0;
      bursts_q <= '0;
      mode_q   <= PAT_INCR;
    end else if (accept) begin
      len_q    <= cfg_len_i;
      bursts_q <= cfg_bursts_i;
      mode_q   <= decode_mode(cfg_mode_i);
    end
  end

  // Beat-within-burst and burst counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q  <= '0;
      burst_q <= '0;
    end else if (accept) begin
      beat_q  <= '0;
      burst_q <= '0;
    end else if (hs) begin
      if (w_last_o) begin
        beat_q  <= '0;
        burst_q <= burst_q + BURST_ONE;
      end else begin
        beat_q  <= beat_q + 8'd1;
      end
    end
  end

  // Credit counter, sticky overflow flag and the done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= (err_q && !accept) || cred_ovf;
      done_q   <= (accept && cfg_bursts_i == '0) || run_end;
    end
  end

  // The mode applied on load must come from the config port, not the stale latch.
  assign pat_mode = accept ? decode_mode(cfg_mode_i) : mode_q;

  axi_w_pattern_gen u_pattern (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (accept),
    .advance_i (hs),
    .mode_i    (pat_mode),
    .seed_i    (cfg_seed_i),
    .word_o    (pat_word)
  );

  assign w_valid_o    = (state_q == ST_DATA);
  assign w_last_o     = (state_q == ST_DATA) && (beat_q == len_q);
  assign w_data_o     = {(DATA_WIDTH/32){pat_word}};
  assign w_strb_o     = '1;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign credit_err_o = err_q;

`ifdef AXI_W_STREAM_GEN_STALL_CNT_EN
  logic [31:0] stall_q;

  // Saturating count of cycles where a beat is offered but not taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (w_valid_o && !w_ready_i && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
`endif

endmodule
